// File: rtl/hacd_id_narrow_pkg.sv
// hacd_id_narrow_pkg: default widths, slot record and priority encoder shared by
// axi_id_narrow and its remap tables.
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 6
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 1
`endif

package hacd_id_narrow_pkg;

    localparam int DEF_ID_WIDTH_IN = `HACD_AXI4_ID_WIDTH;
    localparam int DEF_DATA_WIDTH  = `HACD_AXI4_DATA_WIDTH;
    localparam int DEF_ADDR_WIDTH  = `HACD_AXI4_ADDR_WIDTH;
    localparam int DEF_USER_WIDTH  = `HACD_AXI4_USER_WIDTH;

    localparam int DEF_ID_WIDTH_OUT = DEF_ID_WIDTH_IN - 1;
    localparam int DEF_MAX_OUTST    = 8;
    localparam int NSLOT            = 2 ** DEF_ID_WIDTH_OUT;
    localparam int CNT_WIDTH        = $clog2(DEF_MAX_OUTST + 1);

    // Slot record at the default widths; each table builds the same shape at its
    // own instance widths.
    typedef struct packed {
        logic                       vld;
        logic [DEF_ID_WIDTH_IN-1:0] orig_id;
        logic [CNT_WIDTH-1:0]       cnt;
    } id_slot_t;

    // Widest slot vector the encoder handles (ID_WIDTH_OUT up to 8).
    localparam int ENC_WIDTH = 256;

    // Index of the lowest set bit; returns 0 for an all-zero vector, so callers
    // qualify the result with an OR-reduction of the same vector.
    function automatic int unsigned first_free(input logic [ENC_WIDTH-1:0] vec);
        first_free = 0;
        for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) first_free = i;
        end
    endfunction

endpackage

// File: rtl/axi_id_remap_table.sv
// axi_id_remap_table: one direction's slot table. Allocation maps a wide request ID
// onto a narrow slot (reusing a live slot with the same ID to keep ordering), release
// retires one outstanding transaction and returns the original wide ID.
// Optional check: HACD_ID_NARROW_CHK_EN flags releases on empty slots.
module axi_id_remap_table
    import hacd_id_narrow_pkg::*;
#(
    parameter int ID_WIDTH_IN  = DEF_ID_WIDTH_IN,
    parameter int ID_WIDTH_OUT = DEF_ID_WIDTH_OUT,
    parameter int MAX_OUTST    = DEF_MAX_OUTST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH_IN-1:0]  alloc_id_i,
    input  logic                    alloc_fire_i,
    output logic [ID_WIDTH_OUT-1:0] alloc_slot_o,
    output logic                    can_acc_o,
    input  logic [ID_WIDTH_OUT-1:0] rel_slot_i,
    input  logic                    rel_fire_i,
    output logic [ID_WIDTH_IN-1:0]  rel_orig_id_o,
    output logic                    err_o
);

    localparam int NS = 2 ** ID_WIDTH_OUT;
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic                   vld;
        logic [ID_WIDTH_IN-1:0] orig_id;
        logic [CW-1:0]          cnt;
    } slot_t;

    slot_t                   slot_q [NS];
    slot_t                   slot_d [NS];
    logic [NS-1:0]           hit_vec;
    logic [NS-1:0]           free_vec;
    logic [NS-1:0]           inc_vec;
    logic [NS-1:0]           dec_vec;
    logic                    hit_any;
    logic                    free_any;
    logic [ID_WIDTH_OUT-1:0] hit_idx;
    logic [ID_WIDTH_OUT-1:0] free_idx;

    // Match the request ID against live slots and mark free slots (registered state only).
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            hit_vec[k]  = slot_q[k].vld && (slot_q[k].orig_id == alloc_id_i);
            free_vec[k] = !slot_q[k].vld;
        end
    end

    assign hit_any  = |hit_vec;
    assign free_any = |free_vec;
    assign hit_idx  = ID_WIDTH_OUT'(first_free(ENC_WIDTH'(hit_vec)));
    assign free_idx = ID_WIDTH_OUT'(first_free(ENC_WIDTH'(free_vec)));

    // A live slot with the same ID wins so same-ID transactions stay in order.
    assign alloc_slot_o  = hit_any ? hit_idx : free_idx;
    assign can_acc_o     = hit_any ? (slot_q[hit_idx].cnt < CW'(MAX_OUTST)) : free_any;
    assign rel_orig_id_o = slot_q[rel_slot_i].orig_id;

`ifdef HACD_ID_NARROW_CHK_EN
    logic rel_bad;
    assign rel_bad = !slot_q[rel_slot_i].vld || (slot_q[rel_slot_i].cnt == '0);
`endif

    // Decode which slot is allocated and which is released this cycle.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            inc_vec[k] = alloc_fire_i && (alloc_slot_o == ID_WIDTH_OUT'(k));
`ifdef HACD_ID_NARROW_CHK_EN
            dec_vec[k] = rel_fire_i && (rel_slot_i == ID_WIDTH_OUT'(k)) && !rel_bad;
`else
            dec_vec[k] = rel_fire_i && (rel_slot_i == ID_WIDTH_OUT'(k));
`endif
        end
    end

    // Next-state for every slot: allocate, release, or both (which cancel out).
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            // NOTE: start from the held value so every path assigns slot_d and no latch is inferred.
            slot_d[k] = slot_q[k];
            unique case ({inc_vec[k], dec_vec[k]})
                2'b10: begin
                    slot_d[k].vld     = 1'b1;
                    slot_d[k].orig_id = alloc_id_i;
                    slot_d[k].cnt     = slot_q[k].cnt + CW'(1);
                end
                2'b01: begin
                    slot_d[k].cnt = slot_q[k].cnt - CW'(1);
                    slot_d[k].vld = (slot_q[k].cnt != CW'(1));
                end
                default: ;
            endcase
        end
    end

    // Slot table registers; cleared asynchronously so a reset drops every mapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is ownership state, not data storage, so every entry is reset.
            for (int k = 0; k < NS; k++) slot_q[k] <= '0;
        end else begin
            // NOTE: non-blocking updates keep all slots sampling the same pre-edge state.
            for (int k = 0; k < NS; k++) slot_q[k] <= slot_d[k];
        end
    end

`ifdef HACD_ID_NARROW_CHK_EN
    logic err_q;

    // Sticky flag for a response handshake that targets an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (rel_fire_i && rel_bad) begin
            err_q <= 1'b1;
            $error("axi_id_narrow: response on empty slot %0d", rel_slot_i);
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/axi_id_narrow.sv
// axi_id_narrow: narrows wide AXI IDs to slot indices ahead of the crossbar and
// restores them on B/R. Address channels are combinational; W passes straight through.
// Optional check: define HACD_ID_NARROW_CHK_EN for the sticky id_err response check.
module axi_id_narrow
    import hacd_id_narrow_pkg::*;
#(
    parameter int ID_WIDTH_IN  = DEF_ID_WIDTH_IN,
    parameter int ID_WIDTH_OUT = DEF_ID_WIDTH_OUT,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int USER_WIDTH   = DEF_USER_WIDTH,
    parameter int MAX_OUTST    = DEF_MAX_OUTST
) (
    input  logic                    clk,
    input  logic                    rst,
    // Slave side, AW
    input  logic [ID_WIDTH_IN-1:0]  s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic [USER_WIDTH-1:0]   s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    // Slave side, W
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [USER_WIDTH-1:0]   s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    // Slave side, B
    output logic [ID_WIDTH_IN-1:0]  s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [USER_WIDTH-1:0]   s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // Slave side, AR
    input  logic [ID_WIDTH_IN-1:0]  s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic [USER_WIDTH-1:0]   s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // Slave side, R
    output logic [ID_WIDTH_IN-1:0]  s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [USER_WIDTH-1:0]   s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // Master side, AW
    output logic [ID_WIDTH_OUT-1:0] m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    output logic [USER_WIDTH-1:0]   m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // Master side, W
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic [USER_WIDTH-1:0]   m_axi_wuser,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // Master side, B
    input  logic [ID_WIDTH_OUT-1:0] m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic [USER_WIDTH-1:0]   m_axi_buser,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // Master side, AR
    output logic [ID_WIDTH_OUT-1:0] m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    output logic [USER_WIDTH-1:0]   m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // Master side, R
    input  logic [ID_WIDTH_OUT-1:0] m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [USER_WIDTH-1:0]   m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    // Status
    output logic                    id_err
);

    logic                    aw_can;
    logic                    ar_can;
    logic [ID_WIDTH_OUT-1:0] aw_slot;
    logic [ID_WIDTH_OUT-1:0] ar_slot;
    logic                    wr_err;
    logic                    rd_err;

    // AW: gated by slot availability, which depends only on the ID and registered
    // table state, never on awvalid.
    assign m_axi_awvalid  = s_axi_awvalid & aw_can;
    assign s_axi_awready  = m_axi_awready & aw_can;
    assign m_axi_awid     = aw_slot;
    assign m_axi_awaddr   = s_axi_awaddr;
    assign m_axi_awlen    = s_axi_awlen;
    assign m_axi_awsize   = s_axi_awsize;
    assign m_axi_awburst  = s_axi_awburst;
    assign m_axi_awlock   = s_axi_awlock;
    assign m_axi_awcache  = s_axi_awcache;
    assign m_axi_awprot   = s_axi_awprot;
    assign m_axi_awqos    = s_axi_awqos;
    assign m_axi_awregion = s_axi_awregion;
    assign m_axi_awuser   = s_axi_awuser;

    // W is untracked; the crossbar orders it against AW.
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign m_axi_wuser  = s_axi_wuser;
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;

    // B: payload passes through, ID comes back from the write table.
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_buser  = m_axi_buser;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    // AR: same gating as AW against the read table.
    assign m_axi_arvalid  = s_axi_arvalid & ar_can;
    assign s_axi_arready  = m_axi_arready & ar_can;
    assign m_axi_arid     = ar_slot;
    assign m_axi_araddr   = s_axi_araddr;
    assign m_axi_arlen    = s_axi_arlen;
    assign m_axi_arsize   = s_axi_arsize;
    assign m_axi_arburst  = s_axi_arburst;
    assign m_axi_arlock   = s_axi_arlock;
    assign m_axi_arcache  = s_axi_arcache;
    assign m_axi_arprot   = s_axi_arprot;
    assign m_axi_arqos    = s_axi_arqos;
    assign m_axi_arregion = s_axi_arregion;
    assign m_axi_aruser   = s_axi_aruser;

    // R: payload passes through, ID comes back from the read table.
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_ruser  = m_axi_ruser;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;

    axi_id_remap_table #(
        .ID_WIDTH_IN  (ID_WIDTH_IN),
        .ID_WIDTH_OUT (ID_WIDTH_OUT),
        .MAX_OUTST    (MAX_OUTST)
    ) u_wr_table (
        .clk           (clk),
        .rst           (rst),
        .alloc_id_i    (s_axi_awid),
        .alloc_fire_i  (m_axi_awvalid & m_axi_awready),
        .alloc_slot_o  (aw_slot),
        .can_acc_o     (aw_can),
        .rel_slot_i    (m_axi_bid),
        .rel_fire_i    (m_axi_bvalid & s_axi_bready),
        .rel_orig_id_o (s_axi_bid),
        .err_o         (wr_err)
    );

    // Only the last beat of a read burst retires the transaction.
    axi_id_remap_table #(
        .ID_WIDTH_IN  (ID_WIDTH_IN),
        .ID_WIDTH_OUT (ID_WIDTH_OUT),
        .MAX_OUTST    (MAX_OUTST)
    ) u_rd_table (
        .clk           (clk),
        .rst           (rst),
        .alloc_id_i    (s_axi_arid),
        .alloc_fire_i  (m_axi_arvalid & m_axi_arready),
        .alloc_slot_o  (ar_slot),
        .can_acc_o     (ar_can),
        .rel_slot_i    (m_axi_rid),
        .rel_fire_i    (m_axi_rvalid & s_axi_rready & m_axi_rlast),
        .rel_orig_id_o (s_axi_rid),
        .err_o         (rd_err)
    );

    assign id_err = wr_err | rd_err;

endmodule

// File: tb/tb_axi_id_narrow.sv
// tb_axi_id_narrow: directed stimulus with a queue-based scoreboard for axi_id_narrow.
// Narrow config (4 slots, 8 outstanding per slot) so full and saturation cases are short.
module tb_axi_id_narrow;

    localparam int IW = 6;
    localparam int OW = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int UW = 4;
    localparam int MO = 8;

    logic clk;
    logic rst;

    logic [IW-1:0]   s_awid;
    logic [AW-1:0]   s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awlock;
    logic [3:0]      s_awcache;
    logic [2:0]      s_awprot;
    logic [3:0]      s_awqos;
    logic [3:0]      s_awregion;
    logic [UW-1:0]   s_awuser;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wlast;
    logic [UW-1:0]   s_wuser;
    logic            s_wvalid;
    logic            s_wready;
    logic [IW-1:0]   s_bid;
    logic [1:0]      s_bresp;
    logic [UW-1:0]   s_buser;
    logic            s_bvalid;
    logic            s_bready;
    logic [IW-1:0]   s_arid;
    logic [AW-1:0]   s_araddr;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic            s_arlock;
    logic [3:0]      s_arcache;
    logic [2:0]      s_arprot;
    logic [3:0]      s_arqos;
    logic [3:0]      s_arregion;
    logic [UW-1:0]   s_aruser;
    logic            s_arvalid;
    logic            s_arready;
    logic [IW-1:0]   s_rid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [UW-1:0]   s_ruser;
    logic            s_rvalid;
    logic            s_rready;

    logic [OW-1:0]   m_awid;
    logic [AW-1:0]   m_awaddr;
    logic [7:0]      m_awlen;
    logic [2:0]      m_awsize;
    logic [1:0]      m_awburst;
    logic            m_awlock;
    logic [3:0]      m_awcache;
    logic [2:0]      m_awprot;
    logic [3:0]      m_awqos;
    logic [3:0]      m_awregion;
    logic [UW-1:0]   m_awuser;
    logic            m_awvalid;
    logic            m_awready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wlast;
    logic [UW-1:0]   m_wuser;
    logic            m_wvalid;
    logic            m_wready;
    logic [OW-1:0]   m_bid;
    logic [1:0]      m_bresp;
    logic [UW-1:0]   m_buser;
    logic            m_bvalid;
    logic            m_bready;
    logic [OW-1:0]   m_arid;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_arlock;
    logic [3:0]      m_arcache;
    logic [2:0]      m_arprot;
    logic [3:0]      m_arqos;
    logic [3:0]      m_arregion;
    logic [UW-1:0]   m_aruser;
    logic            m_arvalid;
    logic            m_arready;
    logic [OW-1:0]   m_rid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [UW-1:0]   m_ruser;
    logic            m_rvalid;
    logic            m_rready;
    logic            id_err;

    int checks   = 0;
    int failures = 0;
    logic b_ignore = 1'b0;

    logic [OW-1:0] exp_awid [$];
    logic [OW-1:0] exp_arid [$];
    logic [IW-1:0] exp_bid  [$];
    logic [IW-1:0] exp_rid  [$];

`ifdef HACD_ID_NARROW_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    axi_id_narrow #(
        .ID_WIDTH_IN(IW), .ID_WIDTH_OUT(OW), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .USER_WIDTH(UW), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
        .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock),
        .s_axi_awcache(s_awcache), .s_axi_awprot(s_awprot), .s_axi_awqos(s_awqos),
        .s_axi_awregion(s_awregion), .s_axi_awuser(s_awuser), .s_axi_awvalid(s_awvalid),
        .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
        .s_axi_wuser(s_wuser), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_buser(s_buser),
        .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arqos(s_arqos),
        .s_axi_arregion(s_arregion), .s_axi_aruser(s_aruser), .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
        .s_axi_rlast(s_rlast), .s_axi_ruser(s_ruser), .s_axi_rvalid(s_rvalid),
        .s_axi_rready(s_rready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
        .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos),
        .m_axi_awregion(m_awregion), .m_axi_awuser(m_awuser), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wuser(m_wuser), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_buser(m_buser),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
        .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos),
        .m_axi_arregion(m_arregion), .m_axi_aruser(m_aruser), .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_ruser(m_ruser), .m_axi_rvalid(m_rvalid),
        .m_axi_rready(m_rready),
        .id_err(id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=none expected=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake the DUT presents is compared with the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_awvalid && m_awready) begin
                    if (exp_awid.size() == 0) fail_now("aw_unexpected");
                    else check("m_awid", 128'(m_awid), 128'(exp_awid.pop_front()));
                end
                if (m_arvalid && m_arready) begin
                    if (exp_arid.size() == 0) fail_now("ar_unexpected");
                    else check("m_arid", 128'(m_arid), 128'(exp_arid.pop_front()));
                end
                if (s_bvalid && s_bready && !b_ignore) begin
                    if (exp_bid.size() == 0) fail_now("b_unexpected");
                    else check("s_bid", 128'(s_bid), 128'(exp_bid.pop_front()));
                end
                if (s_rvalid && s_rready) begin
                    if (exp_rid.size() == 0) fail_now("r_unexpected");
                    else check("s_rid", 128'(s_rid), 128'(exp_rid.pop_front()));
                end
            end
        end
    end

    task automatic wait_aw_hs();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (s_awready) begin
                tick();
                return;
            end
        end
        fail_now("aw_handshake_timeout");
    endtask

    task automatic wait_ar_hs();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (s_arready) begin
                tick();
                return;
            end
        end
        fail_now("ar_handshake_timeout");
    endtask

    task automatic aw_issue(input logic [IW-1:0] id, input logic [OW-1:0] slot);
        exp_awid.push_back(slot);
        s_awid    = id;
        s_awvalid = 1'b1;
        wait_aw_hs();
        s_awvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [IW-1:0] id, input logic [OW-1:0] slot);
        exp_arid.push_back(slot);
        s_arid    = id;
        s_arvalid = 1'b1;
        wait_ar_hs();
        s_arvalid = 1'b0;
    endtask

    task automatic r_drive(input logic [OW-1:0] slot, input logic last, input logic [IW-1:0] wide);
        exp_rid.push_back(wide);
        m_rid    = slot;
        m_rlast  = last;
        m_rvalid = 1'b1;
    endtask

    task automatic r_beat(input logic [OW-1:0] slot, input logic last, input logic [IW-1:0] wide);
        r_drive(slot, last, wide);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic b_beat(input logic [OW-1:0] slot, input logic [IW-1:0] wide);
        exp_bid.push_back(wide);
        m_bid    = slot;
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_awid = '0; s_awaddr = 32'h1000_0040; s_awlen = 8'd3; s_awsize = 3'd2;
        s_awburst = 2'b01; s_awlock = 1'b0; s_awcache = 4'h3; s_awprot = 3'd1;
        s_awqos = 4'h5; s_awregion = 4'h2; s_awuser = 4'hA; s_awvalid = 1'b0;
        s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wlast = 1'b1; s_wuser = 4'h6; s_wvalid = 1'b0;
        s_bready = 1'b1;
        s_arid = '0; s_araddr = 32'h2000_0080; s_arlen = 8'd7; s_arsize = 3'd3;
        s_arburst = 2'b10; s_arlock = 1'b1; s_arcache = 4'hC; s_arprot = 3'd6;
        s_arqos = 4'h9; s_arregion = 4'h4; s_aruser = 4'h3; s_arvalid = 1'b0;
        s_rready = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bid = '0; m_bresp = 2'b01; m_buser = 4'h7; m_bvalid = 1'b0;
        m_rid = '0; m_rdata = 32'h1234_5678; m_rresp = 2'b10; m_rlast = 1'b0;
        m_ruser = 4'hB; m_rvalid = 1'b0;

        // Reset state
        @(negedge clk);
        check("id_err_in_reset", 128'(id_err), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("arready_follows_m", 128'(s_arready), 128'(1));
        check("awready_follows_m", 128'(s_awready), 128'(1));
        check("id_err_after_reset", 128'(id_err), 128'(0));
        tick();
        m_arready = 1'b0;
        m_awready = 1'b0;
        @(negedge clk);
        check("arready_m_low", 128'(s_arready), 128'(0));
        check("awready_m_low", 128'(s_awready), 128'(0));
        tick();
        m_arready = 1'b1;
        m_awready = 1'b1;

        // Pass-through of payloads and W
        s_wvalid = 1'b1;
        s_bready = 1'b0;
        @(negedge clk);
        check("aw_payload", 128'({m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awregion, m_awuser}),
              128'({s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awregion, s_awuser}));
        check("ar_payload", 128'({m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser}),
              128'({s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion, s_aruser}));
        check("w_payload", 128'({m_wdata, m_wstrb, m_wlast, m_wuser, m_wvalid, s_wready}),
              128'({s_wdata, s_wstrb, s_wlast, s_wuser, s_wvalid, m_wready}));
        check("b_payload", 128'({s_bresp, s_buser, s_bvalid, m_bready}),
              128'({m_bresp, m_buser, m_bvalid, s_bready}));
        check("r_payload", 128'({s_rdata, s_rresp, s_rlast, s_ruser, s_rvalid, m_rready}),
              128'({m_rdata, m_rresp, m_rlast, m_ruser, m_rvalid, s_rready}));
        tick();
        s_wvalid = 1'b0;
        s_bready = 1'b1;

        // Single read: 0x15 -> slot 0, restored on rlast, slot reused afterwards
        ar_issue(6'h15, 2'd0);
        r_beat(2'd0, 1'b1, 6'h15);
        ar_issue(6'h2A, 2'd0);
        r_beat(2'd0, 1'b1, 6'h2A);

        // Write ordering: same ID shares a slot, slot frees only after both B
        aw_issue(6'h03, 2'd0);
        aw_issue(6'h03, 2'd0);
        aw_issue(6'h07, 2'd1);
        b_beat(2'd0, 6'h03);
        aw_issue(6'h20, 2'd2);
        b_beat(2'd0, 6'h03);
        aw_issue(6'h11, 2'd0);
        b_beat(2'd1, 6'h07);
        b_beat(2'd2, 6'h20);
        b_beat(2'd0, 6'h11);

        // Table full: fifth distinct ID waits for a release, then takes the freed slot
        ar_issue(6'h01, 2'd0);
        ar_issue(6'h02, 2'd1);
        ar_issue(6'h03, 2'd2);
        ar_issue(6'h04, 2'd3);
        exp_arid.push_back(2'd2);
        s_arid = 6'h05;
        s_arvalid = 1'b1;
        @(negedge clk);
        check("full_arready", 128'(s_arready), 128'(0));
        check("full_m_arvalid", 128'(m_arvalid), 128'(0));
        tick();
        r_drive(2'd2, 1'b1, 6'h03);
        @(negedge clk);
        check("full_release_cycle_arready", 128'(s_arready), 128'(0));
        tick();
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        wait_ar_hs();
        s_arvalid = 1'b0;
        r_beat(2'd0, 1'b1, 6'h01);
        r_beat(2'd1, 1'b1, 6'h02);
        r_beat(2'd3, 1'b1, 6'h04);
        r_beat(2'd2, 1'b1, 6'h05);

        // Saturation: nine reads with one ID, the ninth waits for a last beat
        for (int i = 0; i < MO; i++) ar_issue(6'h09, 2'd0);
        exp_arid.push_back(2'd0);
        s_arid = 6'h09;
        s_arvalid = 1'b1;
        @(negedge clk);
        check("sat_arready", 128'(s_arready), 128'(0));
        check("sat_m_arvalid", 128'(m_arvalid), 128'(0));
        tick();
        r_drive(2'd0, 1'b0, 6'h09);
        tick();
        r_drive(2'd0, 1'b1, 6'h09);
        @(negedge clk);
        check("sat_after_nonlast_arready", 128'(s_arready), 128'(0));
        tick();
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        wait_ar_hs();
        s_arvalid = 1'b0;
        for (int i = 0; i < MO; i++) r_beat(2'd0, 1'b1, 6'h09);

        // Same cycle allocate and release on slot 0
        ar_issue(6'h0A, 2'd0);
        exp_arid.push_back(2'd0);
        s_arid = 6'h0A;
        s_arvalid = 1'b1;
        r_drive(2'd0, 1'b1, 6'h0A);
        @(negedge clk);
        check("same_id_same_cycle_arready", 128'(s_arready), 128'(1));
        tick();
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        s_arvalid = 1'b0;
        exp_arid.push_back(2'd1);
        s_arid = 6'h0B;
        s_arvalid = 1'b1;
        r_drive(2'd0, 1'b1, 6'h0A);
        tick();
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        s_arvalid = 1'b0;
        ar_issue(6'h0C, 2'd0);
        r_beat(2'd1, 1'b1, 6'h0B);
        r_beat(2'd0, 1'b1, 6'h0C);

        // Response to an empty write slot
        b_ignore = 1'b1;
        m_bid = 2'd2;
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        b_ignore = 1'b0;
        @(negedge clk);
        check("id_err_after_bad_b", 128'(id_err), 128'(EXP_ERR));
        tick();
        tick();
        tick();
        @(negedge clk);
        check("id_err_sticky", 128'(id_err), 128'(EXP_ERR));

        tick();
        check("awq_drained", 128'(exp_awid.size()), 128'(0));
        check("arq_drained", 128'(exp_arid.size()), 128'(0));
        check("bq_drained", 128'(exp_bid.size()), 128'(0));
        check("rq_drained", 128'(exp_rid.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
